cfg_load_decoder: RTL and testbench
===================================

Name: cfg_load_decoder

Overview:
- Receiving end of the parameter-load protocol that the top-level harness drives onto the shared `image` bus, qualified by `kernel_layer` / `offset_layer`.
- Each cycle the block samples the bus and, when a select is nonzero, unpacks the field positions into one registered write strobe plus address and data for one of six parameter memories: conv1 kernel, conv1 bias, conv2 kernel, conv2 bias, fc bias, fc weight.
- It counts accepted writes per memory, checks index ranges, and raises `cfg_done` once every memory has received its full entry count.
- Sits in `top` between the input ports and the conv1/conv2/fc parameter storage.

Parameters:
- N_C1, 18, conv1 output channels.
- N_C1_SUB, 5, kernel slots per conv1 channel.
- N_C2, 60, conv2 output channels.
- N_FC, 10, fc nodes.
- FI, 960, fc fan-in.
- BIAS_W, 9, bias field width.

Ports:
- clk in 1: rising-edge clock.
- rst_n in 1: synchronous active-low reset.
- image in 1 x [0:783] unpacked: shared image/config bus, index = row*28+col.
- kernel_layer in 2: 1=conv1 kernel, 2=conv2 kernel, 3=fc weight bit, 0=none.
- offset_layer in 2: 1=conv1 bias, 2=conv2 bias, 3=fc bias, 0=none.
- k1_we out 1: conv1 kernel write strobe.
- k1_ch out 5: conv1 channel.
- k1_sub out 3: conv1 slot.
- k2_we out 1: conv2 kernel write strobe.
- k2_ic out 5: conv2 input channel.
- k2_oc out 6: conv2 output channel.
- kern_bits out 25: 5x5 kernel, bit y*5+x.
- b1_we out 1: conv1 bias write strobe.
- b2_we out 1: conv2 bias write strobe.
- fb_we out 1: fc bias write strobe.
- bias_idx out 6: bias channel or node.
- bias_val out 9: bias value.
- fw_we out 1: fc weight write strobe.
- fw_node out 4: fc node.
- fw_idx out 10: fc input index.
- fw_bit out 1: fc weight bit.
- cfg_done out 1: all memories fully loaded and no error.
- cfg_err out 1: sticky protocol error.
- err_code out 3: first error cause.

Behaviour:
- Reset: all outputs 0; counters 0; state EMPTY. Reset wins over any simultaneous load.
- Field map, sampled at the posedge where the select is nonzero:
  - kern_bits[i] = image[i], i = 0..24.
  - k1: sub = image[140..142] (bit0 first); ch = image[112..116].
  - k2: ic = image[112..116]; oc = image[196..201].
  - Bias value = image[84..92], taken from 84+k for bit k; bit 8 is carried through unaltered.
  - b1 index = image[112..117]; b2 index = image[196..201]; fb node = image[168..171].
  - fw: node = image[168..171]; idx = image[224..233]; bit = image[84].
- Latency: one cycle. Exactly one `*_we` is high, for one cycle after the sampling edge. Address/data are valid in that same cycle and hold until the next accepted write.
- Range checks: ch<N_C1, sub<N_C1_SUB, ic<N_C1, oc<N_C2, b1 idx<N_C1, b2 idx<N_C2, node<N_FC, fw_idx<FI.
- A failed range check suppresses the write and sets `cfg_err`.
  - err_code 1 = k1, 2 = k2, 3 = fw, 4 = bias range.
- Both selects nonzero in the same cycle: no write; err_code 5.
- `err_code` latches the first error only.
- Counters, 14b max, increment on each accepted write and saturate at target:
  - k1 = N_C1*N_C1_SUB (90); b1 = 18; b2 = 60; k2 = N_C1*N_C2 (1080); fb = 10; fw = N_FC*FI (9600).
  - Counters count writes, not distinct addresses.
- FSM:
  - EMPTY -> LOAD on the first accepted write.
  - LOAD -> READY when all six counters are at target.
  - Any state -> ERR on an error. ERR exits only by reset.
- cfg_done = (state==READY), registered. It rises in the same cycle as the final `*_we`.
- Writes in READY are accepted as overwrites; the block stays READY.
- Selects of 0 leave all outputs except the strobes unchanged.
- Reset mid-load clears counters and state; previously emitted writes are not retracted.

Decomposition:
- Package `cfg_pkg` holds:
  - Layer-select enums for kernel and offset.
  - Bus bit-offset constants: 84, 112, 140, 168, 196, 224.
  - Target counts.
  - err_code enum.
  - FSM state typedef.
- One sub-module `cfg_cnt_sat`: a saturating counter with a target compare, instantiated six times.

Test Plan:
- Reset, then hold selects at 0 for 5 cycles -> all outputs 0, cfg_done=0, cfg_err=0.
- kernel_layer=1, filter 7 (sub=2, ch=1), kern_bits=25'h1555555 -> next cycle k1_we=1, k1_ch=1, k1_sub=2, kern_bits=25'h1555555; other strobes 0.
- offset_layer=2, idx=59, value=9'h1F3 -> b2_we=1, bias_idx=59, bias_val=9'h1F3. Repeat with idx=60 -> no write, cfg_err=1, err_code=4.
- kernel_layer=3, node=9, idx=959, bit=1 -> fw_we=1. Then idx=960 -> no write, err_code=3, state ERR.
- kernel_layer=1 with offset_layer=1 in the same cycle -> no strobe, err_code=5.
- Full load of 90+18+60+1080+10+9600 writes -> cfg_done rises with the last fw_we. Reset at write 500 instead -> cfg_done=0, and a full reload reaches cfg_done.

Source files
------------

// File: rtl/cfg_pkg.sv
// cfg_pkg: shared definitions for the parameter-load decoder.
//   - network dimensions and per-memory target write counts
//   - bit offsets of the fields carried on the shared image bus
//   - layer-select enums, error codes and FSM state encoding
package cfg_pkg;

  localparam int N_C1     = 18;
  localparam int N_C1_SUB = 5;
  localparam int N_C2     = 60;
  localparam int N_FC     = 10;
  localparam int FI       = 960;
  localparam int BIAS_W   = 9;

  localparam int IMG_N = 784;
  localparam int CNT_W = 14;

  // Field base positions on the image bus (row*28+col, bit0 first).
  localparam int OFS_BIAS  = 84;   // bias value / fc weight bit
  localparam int OFS_CH    = 112;  // k1 ch, k2 ic, b1 idx
  localparam int OFS_SUB   = 140;  // k1 slot
  localparam int OFS_NODE  = 168;  // fc node
  localparam int OFS_OC    = 196;  // k2 oc, b2 idx
  localparam int OFS_FWIDX = 224;  // fc input index

  localparam logic [CNT_W-1:0] TGT_K1 = CNT_W'(N_C1 * N_C1_SUB);
  localparam logic [CNT_W-1:0] TGT_B1 = CNT_W'(N_C1);
  localparam logic [CNT_W-1:0] TGT_B2 = CNT_W'(N_C2);
  localparam logic [CNT_W-1:0] TGT_K2 = CNT_W'(N_C1 * N_C2);
  localparam logic [CNT_W-1:0] TGT_FB = CNT_W'(N_FC);
  localparam logic [CNT_W-1:0] TGT_FW = CNT_W'(N_FC * FI);

  typedef enum logic [1:0] {
    KSEL_NONE  = 2'd0,
    KSEL_CONV1 = 2'd1,
    KSEL_CONV2 = 2'd2,
    KSEL_FC    = 2'd3
  } ksel_e;

  typedef enum logic [1:0] {
    OSEL_NONE  = 2'd0,
    OSEL_CONV1 = 2'd1,
    OSEL_CONV2 = 2'd2,
    OSEL_FC    = 2'd3
  } osel_e;

  typedef enum logic [2:0] {
    ERR_NONE = 3'd0,
    ERR_K1   = 3'd1,
    ERR_K2   = 3'd2,
    ERR_FW   = 3'd3,
    ERR_BIAS = 3'd4,
    ERR_BOTH = 3'd5
  } err_e;

  typedef logic [1:0] state_t;
  localparam state_t ST_EMPTY = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_READY = 2'd2;
  localparam state_t ST_ERR   = 2'd3;

endpackage

// File: rtl/cfg_cnt_sat.sv
// cfg_cnt_sat: saturating write counter with target compare.
//   clk        in  clock
//   rst_n      in  synchronous active-low reset
//   inc        in  count one accepted write this cycle
//   at_tgt_nxt out counter is at TARGET after this edge (current value
//                  already there, or this increment lands on it)
module cfg_cnt_sat
  import cfg_pkg::*;
#(
  parameter logic [CNT_W-1:0] TARGET = '1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  output logic at_tgt_nxt
);

  logic [CNT_W-1:0] cnt;
  logic             full;

  assign full = (cnt == TARGET);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && !full) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Look-ahead so the top can raise cfg_done together with the final strobe.
  assign at_tgt_nxt = full || (inc && (cnt == TARGET - 1'b1));

endmodule

// File: rtl/cfg_load_decoder.sv
// cfg_load_decoder: receives parameter-load beats from the shared image bus
// and turns them into registered write strobes + address/data for the six
// parameter memories (conv1/conv2 kernels and biases, fc bias, fc weight).
//   clk, rst_n               clock, synchronous active-low reset
//   image[0:783]             shared bus, index = row*28+col
//   kernel_layer             1=conv1 kernel, 2=conv2 kernel, 3=fc weight
//   offset_layer             1=conv1 bias, 2=conv2 bias, 3=fc bias
//   k1_we/k1_ch/k1_sub       conv1 kernel write
//   k2_we/k2_ic/k2_oc        conv2 kernel write
//   kern_bits                5x5 kernel shared by k1/k2 writes, bit y*5+x
//   b1_we/b2_we/fb_we        bias writes, sharing bias_idx/bias_val
//   fw_we/fw_node/fw_idx/fw_bit  fc weight write
//   cfg_done                 all memories fully loaded, no error
//   cfg_err/err_code         sticky error flag and first error cause
//
// state    | meaning
// EMPTY    | nothing accepted since reset
// LOAD     | some writes accepted, not every memory full yet
// READY    | every memory reached its count; further writes are overwrites
// ERR      | protocol error seen; left only by reset
module cfg_load_decoder
  import cfg_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                image [0:IMG_N-1],
  input  logic [1:0]          kernel_layer,
  input  logic [1:0]          offset_layer,
  output logic                k1_we,
  output logic [4:0]          k1_ch,
  output logic [2:0]          k1_sub,
  output logic                k2_we,
  output logic [4:0]          k2_ic,
  output logic [5:0]          k2_oc,
  output logic [24:0]         kern_bits,
  output logic                b1_we,
  output logic                b2_we,
  output logic                fb_we,
  output logic [5:0]          bias_idx,
  output logic [BIAS_W-1:0]   bias_val,
  output logic                fw_we,
  output logic [3:0]          fw_node,
  output logic [9:0]          fw_idx,
  output logic                fw_bit,
  output logic                cfg_done,
  output logic                cfg_err,
  output logic [2:0]          err_code
);

  ksel_e             ksel;
  osel_e             osel;
  logic [24:0]       f_kern;
  logic [2:0]        f_sub;
  logic [5:0]        f_ch;
  logic [5:0]        f_oc;
  logic [3:0]        f_node;
  logic [9:0]        f_fwidx;
  logic [BIAS_W-1:0] f_bias;

  logic k1_ok, k2_ok, fw_ok, b1_ok, b2_ok, fb_ok;
  logic we_k1, we_k2, we_b1, we_b2, we_fb, we_fw;
  logic accept, error;
  err_e err_nxt;

  logic [5:0] at_tgt_nxt;
  logic       all_full_nxt;
  state_t     state, state_nxt;

  assign ksel = ksel_e'(kernel_layer);
  assign osel = osel_e'(offset_layer);

  always_comb begin
    f_kern  = '0;
    f_sub   = '0;
    f_ch    = '0;
    f_oc    = '0;
    f_node  = '0;
    f_fwidx = '0;
    f_bias  = '0;
    for (int k = 0; k < 25; k++)     f_kern[k]  = image[k];
    for (int k = 0; k < 3; k++)      f_sub[k]   = image[OFS_SUB + k];
    for (int k = 0; k < 6; k++)      f_ch[k]    = image[OFS_CH + k];
    for (int k = 0; k < 6; k++)      f_oc[k]    = image[OFS_OC + k];
    for (int k = 0; k < 4; k++)      f_node[k]  = image[OFS_NODE + k];
    for (int k = 0; k < 10; k++)     f_fwidx[k] = image[OFS_FWIDX + k];
    for (int k = 0; k < BIAS_W; k++) f_bias[k]  = image[OFS_BIAS + k];
  end

  // k1 channel and k2 input channel are 5 bits; b1 index uses the sixth bit.
  assign k1_ok = (f_ch[4:0] < 5'(N_C1)) && (f_sub < 3'(N_C1_SUB));
  assign k2_ok = (f_ch[4:0] < 5'(N_C1)) && (f_oc < 6'(N_C2));
  assign fw_ok = (f_node < 4'(N_FC)) && (f_fwidx < 10'(FI));
  assign b1_ok = (f_ch < 6'(N_C1));
  assign b2_ok = (f_oc < 6'(N_C2));
  assign fb_ok = (f_node < 4'(N_FC));

  always_comb begin
    we_k1   = 1'b0;
    we_k2   = 1'b0;
    we_b1   = 1'b0;
    we_b2   = 1'b0;
    we_fb   = 1'b0;
    we_fw   = 1'b0;
    err_nxt = ERR_NONE;
    if (ksel != KSEL_NONE && osel != KSEL_NONE) begin
      err_nxt = ERR_BOTH;
    end else begin
      case (ksel)
        KSEL_CONV1: if (k1_ok) we_k1 = 1'b1; else err_nxt = ERR_K1;
        KSEL_CONV2: if (k2_ok) we_k2 = 1'b1; else err_nxt = ERR_K2;
        KSEL_FC:    if (fw_ok) we_fw = 1'b1; else err_nxt = ERR_FW;
        default: ;
      endcase
      case (osel)
        OSEL_CONV1: if (b1_ok) we_b1 = 1'b1; else err_nxt = ERR_BIAS;
        OSEL_CONV2: if (b2_ok) we_b2 = 1'b1; else err_nxt = ERR_BIAS;
        OSEL_FC:    if (fb_ok) we_fb = 1'b1; else err_nxt = ERR_BIAS;
        default: ;
      endcase
    end
  end

  assign accept = we_k1 | we_k2 | we_b1 | we_b2 | we_fb | we_fw;
  assign error  = (err_nxt != ERR_NONE);

  cfg_cnt_sat #(.TARGET(TGT_K1)) u_cnt_k1 (
    .clk(clk), .rst_n(rst_n), .inc(we_k1), .at_tgt_nxt(at_tgt_nxt[0]));
  cfg_cnt_sat #(.TARGET(TGT_B1)) u_cnt_b1 (
    .clk(clk), .rst_n(rst_n), .inc(we_b1), .at_tgt_nxt(at_tgt_nxt[1]));
  cfg_cnt_sat #(.TARGET(TGT_B2)) u_cnt_b2 (
    .clk(clk), .rst_n(rst_n), .inc(we_b2), .at_tgt_nxt(at_tgt_nxt[2]));
  cfg_cnt_sat #(.TARGET(TGT_K2)) u_cnt_k2 (
    .clk(clk), .rst_n(rst_n), .inc(we_k2), .at_tgt_nxt(at_tgt_nxt[3]));
  cfg_cnt_sat #(.TARGET(TGT_FB)) u_cnt_fb (
    .clk(clk), .rst_n(rst_n), .inc(we_fb), .at_tgt_nxt(at_tgt_nxt[4]));
  cfg_cnt_sat #(.TARGET(TGT_FW)) u_cnt_fw (
    .clk(clk), .rst_n(rst_n), .inc(we_fw), .at_tgt_nxt(at_tgt_nxt[5]));

  assign all_full_nxt = &at_tgt_nxt;

  always_comb begin
    state_nxt = state;
    if (error) begin
      state_nxt = ST_ERR;
    end else begin
      case (state)
        ST_EMPTY: if (accept) state_nxt = all_full_nxt ? ST_READY : ST_LOAD;
        ST_LOAD:  if (all_full_nxt) state_nxt = ST_READY;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      err_code  <= '0;
      k1_we     <= 1'b0;
      k2_we     <= 1'b0;
      b1_we     <= 1'b0;
      b2_we     <= 1'b0;
      fb_we     <= 1'b0;
      fw_we     <= 1'b0;
      k1_ch     <= '0;
      k1_sub    <= '0;
      k2_ic     <= '0;
      k2_oc     <= '0;
      kern_bits <= '0;
      bias_idx  <= '0;
      bias_val  <= '0;
      fw_node   <= '0;
      fw_idx    <= '0;
      fw_bit    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cfg_done <= (state_nxt == ST_READY);
      k1_we    <= we_k1;
      k2_we    <= we_k2;
      b1_we    <= we_b1;
      b2_we    <= we_b2;
      fb_we    <= we_fb;
      fw_we    <= we_fw;

      if (error) begin
        cfg_err <= 1'b1;
        if (!cfg_err) err_code <= err_nxt;
      end

      if (we_k1) begin
        k1_ch  <= f_ch[4:0];
        k1_sub <= f_sub;
      end
      if (we_k2) begin
        k2_ic <= f_ch[4:0];
        k2_oc <= f_oc;
      end
      if (we_k1 || we_k2) kern_bits <= f_kern;

      if (we_b1) bias_idx <= f_ch;
      if (we_b2) bias_idx <= f_oc;
      if (we_fb) bias_idx <= {2'b00, f_node};
      if (we_b1 || we_b2 || we_fb) bias_val <= f_bias;

      if (we_fw) begin
        fw_node <= f_node;
        fw_idx  <= f_fwidx;
        fw_bit  <= image[OFS_BIAS];
      end
    end
  end

endmodule

// File: tb/tb_cfg_load_decoder.sv
module tb_cfg_load_decoder;

  logic        clk;
  logic        rst_n;
  logic        image [0:783];
  logic [1:0]  kernel_layer;
  logic [1:0]  offset_layer;
  logic        k1_we, k2_we, b1_we, b2_we, fb_we, fw_we;
  logic [4:0]  k1_ch;
  logic [2:0]  k1_sub;
  logic [4:0]  k2_ic;
  logic [5:0]  k2_oc;
  logic [24:0] kern_bits;
  logic [5:0]  bias_idx;
  logic [8:0]  bias_val;
  logic [3:0]  fw_node;
  logic [9:0]  fw_idx;
  logic        fw_bit;
  logic        cfg_done, cfg_err;
  logic [2:0]  err_code;

  int tests_run = 0;
  int fails = 0;

  wire [5:0] strobes = {k1_we, k2_we, b1_we, b2_we, fb_we, fw_we};

  cfg_load_decoder dut (
    .clk(clk), .rst_n(rst_n), .image(image),
    .kernel_layer(kernel_layer), .offset_layer(offset_layer),
    .k1_we(k1_we), .k1_ch(k1_ch), .k1_sub(k1_sub),
    .k2_we(k2_we), .k2_ic(k2_ic), .k2_oc(k2_oc), .kern_bits(kern_bits),
    .b1_we(b1_we), .b2_we(b2_we), .fb_we(fb_we),
    .bias_idx(bias_idx), .bias_val(bias_val),
    .fw_we(fw_we), .fw_node(fw_node), .fw_idx(fw_idx), .fw_bit(fw_bit),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_image();
    for (int i = 0; i < 784; i++) image[i] = 1'b0;
  endtask

  task automatic set_field(input int base, input int width, input int val);
    for (int k = 0; k < width; k++) image[base + k] = val[k];
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    kernel_layer = 2'd0;
    offset_layer = 2'd0;
    clear_image();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Sets up one valid beat of the given kind; selects stay driven.
  task automatic set_write(input int kind);
    clear_image();
    kernel_layer = 2'd0;
    offset_layer = 2'd0;
    case (kind)
      1: begin set_field(0, 25, 25'h1FFFFFF); set_field(112, 5, 17); set_field(140, 3, 4); kernel_layer = 2'd1; end
      2: begin set_field(84, 9, 9'h100); set_field(112, 6, 17); offset_layer = 2'd1; end
      3: begin set_field(84, 9, 9'h001); set_field(196, 6, 0); offset_layer = 2'd2; end
      4: begin set_field(112, 5, 17); set_field(196, 6, 59); kernel_layer = 2'd2; end
      5: begin set_field(168, 4, 9); offset_layer = 2'd3; end
      default: begin set_field(168, 4, 0); set_field(224, 10, 959); kernel_layer = 2'd3; end
    endcase
  endtask

  task automatic load_burst(input int kind, input int n);
    set_write(kind);
    repeat (n) tick();
    kernel_layer = 2'd0;
    offset_layer = 2'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_write(1);
    tick();
    tests_run++;
    if (k1_we !== 1'b0) begin fails++; $display("FAIL reset_wins: k1_we=%b want 0", k1_we); end
    rst_n = 1'b1;
    kernel_layer = 2'd0;
    clear_image();
    repeat (5) tick();
    tests_run++;
    if (strobes !== 6'b0) begin fails++; $display("FAIL reset_strobes: got %b want 000000", strobes); end
    tests_run++;
    if ({k1_ch, k1_sub, k2_ic, k2_oc, kern_bits, bias_idx, bias_val, fw_node, fw_idx, fw_bit} !== '0) begin
      fails++; $display("FAIL reset_data: nonzero address/data after reset, want 0");
    end
    tests_run++;
    if ({cfg_done, cfg_err, err_code} !== 5'b0) begin
      fails++; $display("FAIL reset_status: got done=%b err=%b code=%0d want 0/0/0", cfg_done, cfg_err, err_code);
    end
  endtask

  task automatic test_k1();
    do_reset();
    clear_image();
    set_field(0, 25, 25'h1555555);
    set_field(140, 3, 2);
    set_field(112, 5, 1);
    kernel_layer = 2'd1;
    tick();
    kernel_layer = 2'd0;
    tests_run++;
    if (strobes !== 6'b100000) begin fails++; $display("FAIL k1_strobes: got %b want 100000", strobes); end
    tests_run++;
    if ({k1_ch, k1_sub} !== {5'd1, 3'd2}) begin fails++; $display("FAIL k1_addr: ch=%0d sub=%0d want 1/2", k1_ch, k1_sub); end
    tests_run++;
    if (kern_bits !== 25'h1555555) begin fails++; $display("FAIL k1_kern: got %h want 1555555", kern_bits); end
    tick();
    tests_run++;
    if (strobes !== 6'b0 || k1_ch !== 5'd1 || kern_bits !== 25'h1555555) begin
      fails++; $display("FAIL k1_hold: strobes=%b ch=%0d kern=%h want 000000/1/1555555", strobes, k1_ch, kern_bits);
    end
  endtask

  task automatic test_k2();
    do_reset();
    clear_image();
    set_field(0, 25, 25'h0ABCDEF);
    set_field(112, 5, 5);
    set_field(196, 6, 33);
    kernel_layer = 2'd2;
    tick();
    tests_run++;
    if (strobes !== 6'b010000 || k2_ic !== 5'd5 || k2_oc !== 6'd33 || kern_bits !== 25'h0ABCDEF) begin
      fails++; $display("FAIL k2_write: strobes=%b ic=%0d oc=%0d kern=%h want 010000/5/33/0abcdef", strobes, k2_ic, k2_oc, kern_bits);
    end
    set_field(196, 6, 60);
    tick();
    kernel_layer = 2'd0;
    tests_run++;
    if (strobes !== 6'b0 || cfg_err !== 1'b1 || err_code !== 3'd2 || k2_oc !== 6'd33) begin
      fails++; $display("FAIL k2_range: strobes=%b err=%b code=%0d oc=%0d want 000000/1/2/33", strobes, cfg_err, err_code, k2_oc);
    end
  endtask

  task automatic test_bias();
    do_reset();
    clear_image();
    set_field(84, 9, 9'h1F3);
    set_field(196, 6, 59);
    offset_layer = 2'd2;
    tick();
    tests_run++;
    if (strobes !== 6'b000100 || bias_idx !== 6'd59 || bias_val !== 9'h1F3) begin
      fails++; $display("FAIL b2_write: strobes=%b idx=%0d val=%h want 000100/59/1f3", strobes, bias_idx, bias_val);
    end
    clear_image();
    set_field(84, 9, 9'h0A5);
    set_field(112, 6, 17);
    offset_layer = 2'd1;
    tick();
    tests_run++;
    if (strobes !== 6'b001000 || bias_idx !== 6'd17 || bias_val !== 9'h0A5) begin
      fails++; $display("FAIL b1_write: strobes=%b idx=%0d val=%h want 001000/17/0a5", strobes, bias_idx, bias_val);
    end
    clear_image();
    set_field(84, 9, 9'h10C);
    set_field(168, 4, 9);
    offset_layer = 2'd3;
    tick();
    tests_run++;
    if (strobes !== 6'b000010 || bias_idx !== 6'd9 || bias_val !== 9'h10C) begin
      fails++; $display("FAIL fb_write: strobes=%b idx=%0d val=%h want 000010/9/10c", strobes, bias_idx, bias_val);
    end
    clear_image();
    set_field(84, 9, 9'h055);
    set_field(196, 6, 60);
    offset_layer = 2'd2;
    tick();
    offset_layer = 2'd0;
    tests_run++;
    if (strobes !== 6'b0 || cfg_err !== 1'b1 || err_code !== 3'd4) begin
      fails++; $display("FAIL b2_range: strobes=%b err=%b code=%0d want 000000/1/4", strobes, cfg_err, err_code);
    end
    tests_run++;
    if (bias_idx !== 6'd9 || bias_val !== 9'h10C) begin
      fails++; $display("FAIL b2_range_hold: idx=%0d val=%h want 9/10c", bias_idx, bias_val);
    end
  endtask

  task automatic test_fw();
    do_reset();
    clear_image();
    set_field(168, 4, 9);
    set_field(224, 10, 959);
    set_field(84, 1, 1);
    kernel_layer = 2'd3;
    tick();
    tests_run++;
    if (strobes !== 6'b000001 || fw_node !== 4'd9 || fw_idx !== 10'd959 || fw_bit !== 1'b1) begin
      fails++; $display("FAIL fw_write: strobes=%b node=%0d idx=%0d bit=%b want 000001/9/959/1", strobes, fw_node, fw_idx, fw_bit);
    end
    set_field(224, 10, 960);
    tick();
    kernel_layer = 2'd0;
    tests_run++;
    if (strobes !== 6'b0 || cfg_err !== 1'b1 || err_code !== 3'd3 || fw_idx !== 10'd959) begin
      fails++; $display("FAIL fw_range: strobes=%b err=%b code=%0d idx=%0d want 000000/1/3/959", strobes, cfg_err, err_code, fw_idx);
    end
  endtask

  task automatic test_both_selects();
    do_reset();
    set_write(1);
    offset_layer = 2'd1;
    tick();
    tests_run++;
    if (strobes !== 6'b0 || cfg_err !== 1'b1 || err_code !== 3'd5) begin
      fails++; $display("FAIL both_sel: strobes=%b err=%b code=%0d want 000000/1/5", strobes, cfg_err, err_code);
    end
    offset_layer = 2'd0;
    set_field(112, 5, 18);
    tick();
    kernel_layer = 2'd0;
    tests_run++;
    if (strobes !== 6'b0 || err_code !== 3'd5) begin
      fails++; $display("FAIL first_err_kept: strobes=%b code=%0d want 000000/5", strobes, err_code);
    end
  endtask

  task automatic full_load_checked(input string tag);
    load_burst(1, 90);
    load_burst(2, 18);
    load_burst(3, 60);
    load_burst(4, 1080);
    load_burst(5, 10);
    tests_run++;
    if (cfg_done !== 1'b0) begin fails++; $display("FAIL %s_early_done: cfg_done=%b want 0", tag, cfg_done); end
    load_burst(6, 9599);
    tests_run++;
    if (strobes !== 6'b000001 || cfg_done !== 1'b0) begin
      fails++; $display("FAIL %s_penultimate: strobes=%b done=%b want 000001/0", tag, strobes, cfg_done);
    end
    load_burst(6, 1);
    tests_run++;
    if (strobes !== 6'b000001 || cfg_done !== 1'b1 || cfg_err !== 1'b0) begin
      fails++; $display("FAIL %s_last: strobes=%b done=%b err=%b want 000001/1/0", tag, strobes, cfg_done, cfg_err);
    end
  endtask

  task automatic test_full_load();
    do_reset();
    full_load_checked("full");
    tick();
    tests_run++;
    if (strobes !== 6'b0 || cfg_done !== 1'b1) begin
      fails++; $display("FAIL ready_idle: strobes=%b done=%b want 000000/1", strobes, cfg_done);
    end
    load_burst(1, 1);
    tests_run++;
    if (strobes !== 6'b100000 || cfg_done !== 1'b1 || cfg_err !== 1'b0) begin
      fails++; $display("FAIL ready_overwrite: strobes=%b done=%b err=%b want 100000/1/0", strobes, cfg_done, cfg_err);
    end
  endtask

  task automatic test_midload_reset();
    do_reset();
    load_burst(1, 90);
    load_burst(2, 18);
    load_burst(3, 60);
    load_burst(4, 332);
    rst_n = 1'b0;
    tick();
    tests_run++;
    if (cfg_done !== 1'b0 || strobes !== 6'b0) begin
      fails++; $display("FAIL midload_reset: done=%b strobes=%b want 0/000000", cfg_done, strobes);
    end
    rst_n = 1'b1;
    full_load_checked("reload");
  endtask

  initial begin
    rst_n = 1'b0;
    kernel_layer = 2'd0;
    offset_layer = 2'd0;
    clear_image();
    test_reset();
    test_k1();
    test_k2();
    test_bias();
    test_fw();
    test_both_selects();
    test_full_load();
    test_midload_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
